// File: rtl/routex_pktgen_pkg.sv
// Shared types and constants for the router-port packet generator.
// A hop word is valid when its top byte is nonzero.
package routex_pktgen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StBody
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic        head;
    logic        tail;
  } flit_t;

  localparam int unsigned HOP_VALID_MSB = 63;
  localparam int unsigned HOP_VALID_LSB = 56;

  function automatic logic hop_valid(input logic [63:0] word);
    return |word[HOP_VALID_MSB:HOP_VALID_LSB];
  endfunction

endpackage

// File: rtl/routex_hop_count.sv
// Combinational header-length finder: index of the first invalid hop word at or above 1.
// Word 0 always counts, so the result lies in 1..NumHops.
module routex_hop_count
  import routex_pktgen_pkg::*;
#(
  parameter int unsigned NumHops = 8,
  parameter int unsigned CntW    = $clog2(NumHops + 1)
) (
  input  logic [NumHops-1:0][63:0] i_dest,
  output logic [CntW-1:0]          o_hops
);

  localparam int unsigned IdxW = (NumHops > 1) ? $clog2(NumHops) : 1;

  logic w_found;

  always_comb begin
    o_hops  = CntW'(NumHops);
    w_found = 1'b0;
    for (int i = 1; i < int'(NumHops); i++) begin
      if (!w_found && !hop_valid(i_dest[IdxW'(i)])) begin
        o_hops  = CntW'(i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/routex_pktgen.sv
// Per-port packet source: on GO, emits the latched source-route header then LEN payload
// flits as 64-bit flits with HEAD/TAIL marking, honouring per-cycle back-pressure.
module routex_pktgen
  import routex_pktgen_pkg::*;
#(
  parameter int unsigned NumHops = 8,
  parameter int unsigned PortId  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NumHops-1:0][63:0] i_dest,
  input  logic [63:0]              i_len,
  input  logic                     i_go,
  input  logic                     i_bp,
  output logic                     o_out_valid,
  output logic [63:0]              o_out_data,
  output logic                     o_out_head,
  output logic                     o_out_tail,
  output logic                     o_busy,
  output logic [31:0]              o_pkt_cnt,
  output logic [15:0]              o_go_drop
);

  localparam int unsigned CntW     = $clog2(NumHops + 1);
  localparam int unsigned IdxW     = (NumHops > 1) ? $clog2(NumHops) : 1;
  localparam logic [7:0]  PortByte = 8'(PortId);

  state_e                   r_state;
  logic [NumHops-1:0][63:0] r_dest;
  logic [63:0]              r_len;
  logic [63:0]              r_k;
  logic [IdxW-1:0]          r_idx;
  logic [IdxW-1:0]          r_last_idx;
  logic [7:0]               r_pkt_id;
  flit_t                    r_flit;
  logic                     r_active;
  logic [31:0]              r_pkt_cnt;
  logic [15:0]              r_go_drop;

  logic [CntW-1:0] w_hops;
  logic [IdxW-1:0] w_go_last;
  logic [IdxW-1:0] w_idx_nxt;
  logic [63:0]     w_k_nxt;
  logic            w_accept;

  routex_hop_count #(
    .NumHops (NumHops),
    .CntW    (CntW)
  ) u_hop_count (
    .i_dest (i_dest),
    .o_hops (w_hops)
  );

  function automatic logic [63:0] payload(input logic [7:0] id, input logic [63:0] k);
    return {PortByte, id, k[47:0]};
  endfunction

  assign w_go_last = IdxW'(w_hops - CntW'(1));
  assign w_idx_nxt = r_idx + IdxW'(1);
  assign w_k_nxt   = r_k + 64'd1;
  assign w_accept  = r_active & ~i_bp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_dest     <= '0;
      r_len      <= '0;
      r_k        <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_pkt_id   <= '0;
      r_flit     <= '0;
      r_active   <= 1'b0;
      r_pkt_cnt  <= '0;
      r_go_drop  <= '0;
    end else begin
      // Any GO seen outside IDLE is dropped, including on the tail-accept edge.
      if (i_go && (r_state != StIdle) && (r_go_drop != 16'hFFFF)) begin
        r_go_drop <= r_go_drop + 16'd1;
      end

      if (w_accept && r_flit.tail) begin
        r_state   <= StIdle;
        r_active  <= 1'b0;
        r_flit    <= '{data: r_flit.data, head: 1'b0, tail: 1'b0};
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_go) begin
              r_dest     <= i_dest;
              r_len      <= i_len;
              r_last_idx <= w_go_last;
              r_idx      <= '0;
              r_k        <= '0;
              r_pkt_id   <= r_pkt_cnt[7:0];
              r_active   <= 1'b1;
              r_flit     <= '{data: i_dest[0], head: 1'b1,
                              tail: (w_go_last == '0) && (i_len == '0)};
              r_state    <= StHead;
            end
          end
          StHead: begin
            if (w_accept) begin
              if (r_idx == r_last_idx) begin
                r_state <= StBody;
                r_flit  <= '{data: payload(r_pkt_id, 64'd0), head: 1'b0,
                             tail: (r_len == 64'd1)};
              end else begin
                r_idx  <= w_idx_nxt;
                r_flit <= '{data: r_dest[w_idx_nxt], head: 1'b0,
                            tail: (w_idx_nxt == r_last_idx) && (r_len == '0)};
              end
            end
          end
          StBody: begin
            if (w_accept) begin
              r_k    <= w_k_nxt;
              r_flit <= '{data: payload(r_pkt_id, w_k_nxt), head: 1'b0,
                          tail: (w_k_nxt == r_len - 64'd1)};
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_out_valid = r_active;
  assign o_busy      = r_active;
  assign o_out_data  = r_flit.data;
  assign o_out_head  = r_flit.head;
  assign o_out_tail  = r_flit.tail;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_go_drop   = r_go_drop;

endmodule

// File: tb/tb_routex_pktgen.sv
// Randomised self-checking bench for routex_pktgen against a queue-based packet model.
module tb_routex_pktgen;

  localparam logic [7:0] PORT = 8'h5A;

  typedef struct packed {
    logic [63:0] data;
    logic        head;
    logic        tail;
  } fl_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0][63:0] dest;
  logic [63:0]      len;
  logic             go;
  logic             bp;
  logic             o_valid;
  logic [63:0]      o_data;
  logic             o_head;
  logic             o_tail;
  logic             o_busy;
  logic [31:0]      o_pkt_cnt;
  logic [15:0]      o_go_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  routex_pktgen #(
    .NumHops (8),
    .PortId  (32'h5A)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_dest      (dest),
    .i_len       (len),
    .i_go        (go),
    .i_bp        (bp),
    .o_out_valid (o_valid),
    .o_out_data  (o_data),
    .o_out_head  (o_head),
    .o_out_tail  (o_tail),
    .o_busy      (o_busy),
    .o_pkt_cnt   (o_pkt_cnt),
    .o_go_drop   (o_go_drop)
  );

  // ---------------- reference model ----------------
  function automatic int hops_of(input logic [7:0][63:0] d);
    int h = 1;
    while (h < 8 && d[h][63:56] != 8'h00) h++;
    return h;
  endfunction

  task automatic build_pkt(input logic [7:0][63:0] d, input longint unsigned n,
                           input logic [7:0] id, output fl_t q[$]);
    int h = hops_of(d);
    longint unsigned total = longint'(h) + n;
    longint unsigned k;
    q = {};
    for (int i = 0; i < h; i++)
      q.push_back(fl_t'{data: d[i], head: (i == 0), tail: (longint'(i) == total - 1)});
    for (k = 0; k < n; k++)
      q.push_back(fl_t'{data: {PORT, id, k[47:0]}, head: 1'b0,
                        tail: (longint'(h) + k == total - 1)});
  endtask

  function automatic logic [63:0] rnd_word(input bit valid);
    logic [63:0] w = {$urandom, $urandom};
    w[63:56] = valid ? 8'($urandom_range(1, 255)) : 8'h00;
    return w;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    go    = 1'b0;
    bp    = 1'b0;
    len   = '0;
    dest  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_go(input logic [7:0][63:0] d, input logic [63:0] l);
    dest = d;
    len  = l;
    go   = 1'b1;
  endtask

  // Cycle c = negedges after the GO edge; bp for the following edge is decided at negedge c.
  task automatic collect(input int bp_lo, input int bp_hi, input bit rnd_bp, input int go_c,
                         input logic [63:0] go_len, input int max_c, output fl_t got[$],
                         output int first_c, output int tail_c, output int unstable);
    fl_t cur, prev;
    bit  prev_stall = 1'b0;
    bit  bpv;
    got = {};
    first_c = -1;
    tail_c = -1;
    unstable = 0;
    prev = '0;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      go  = 1'b0;
      cur = fl_t'{data: o_data, head: o_head, tail: o_tail};
      if (prev_stall && (!o_valid || cur !== prev)) unstable++;
      bpv = (c >= bp_lo && c < bp_hi) || (rnd_bp && $urandom_range(0, 3) == 0);
      if (o_valid && first_c < 0) first_c = c;
      if (o_valid && !bpv) begin
        got.push_back(cur);
        if (cur.tail) tail_c = c;
      end
      prev_stall = o_valid && bpv;
      prev = cur;
      if (c == go_c) begin
        go  = 1'b1;
        len = go_len;
      end
      bp = bpv;
      if (tail_c >= 0) break;
    end
    bp = 1'b0;
    go = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    repeat (20) @(negedge clk);
    n_checks++;
    if ({o_valid, o_head, o_tail, o_busy, o_data, o_pkt_cnt, o_go_drop} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b h=%b t=%b busy=%b data=%h cnt=%0d drop=%0d, required all 0",
               o_valid, o_head, o_tail, o_busy, o_data, o_pkt_cnt, o_go_drop);
    end
  endtask

  task automatic test_basic(input bit with_bp);
    logic [7:0][63:0] d = '0;
    fl_t got[$], exp[$];
    int first_c, tail_c, unstable;
    apply_reset();
    d[0] = {8'h01, 56'h4};
    start_go(d, 64'd500);
    if (with_bp) collect(40, 140, 1'b0, -1, '0, 3000, got, first_c, tail_c, unstable);
    else         collect(-1, -1, 1'b0, -1, '0, 3000, got, first_c, tail_c, unstable);
    build_pkt(d, 500, 8'h00, exp);
    n_checks++;
    if (first_c != 0) begin
      n_fail++;
      $display("FAIL basic_latency(bp=%0b): first flit at cycle %0d, required 0", with_bp, first_c);
    end
    n_checks++;
    if (got.size() != 501) begin
      n_fail++;
      $display("FAIL basic_count(bp=%0b): got %0d flits, required 501", with_bp, got.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_flit%0d(bp=%0b): got %h, required %h", i, with_bp, got[i], exp[i]);
      end
    end
    n_checks++;
    if (got.size() == 501 && got[500] !== fl_t'{data: {PORT, 8'h00, 48'd499}, head: 1'b0, tail: 1'b1}) begin
      n_fail++;
      $display("FAIL basic_tail_flit(bp=%0b): got %h", with_bp, got[500]);
    end
    n_checks++;
    if (tail_c != (with_bp ? 600 : 500)) begin
      n_fail++;
      $display("FAIL basic_tail_cycle(bp=%0b): got %0d, required %0d", with_bp, tail_c,
               with_bp ? 600 : 500);
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d stalled cycles changed outputs, required 0", unstable);
    end
    @(negedge clk);
    n_checks++;
    if (o_pkt_cnt !== 32'd1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done(bp=%0b): cnt=%0d v=%b busy=%b, required 1 0 0", with_bp,
               o_pkt_cnt, o_valid, o_busy);
    end
  endtask

  task automatic test_go_drop();
    logic [7:0][63:0] d = '0;
    fl_t got[$], exp[$];
    int first_c, tail_c, unstable;
    apply_reset();
    d[0] = rnd_word(1'b1);
    d[1] = rnd_word(1'b0);
    start_go(d, 64'd300);
    collect(-1, -1, 1'b0, 10, 64'd77, 2000, got, first_c, tail_c, unstable);
    build_pkt(d, 300, 8'h00, exp);
    n_checks++;
    if (got.size() != 301 || got != exp) begin
      n_fail++;
      $display("FAIL drop_pkt1: got %0d flits (or content differs), required 301", got.size());
    end
    @(negedge clk);
    n_checks++;
    if (o_go_drop !== 16'd1 || o_pkt_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL drop_count1: drop=%0d cnt=%0d, required 1 1", o_go_drop, o_pkt_cnt);
    end
    start_go(d, 64'd100);
    collect(-1, -1, 1'b1, -1, '0, 2000, got, first_c, tail_c, unstable);
    build_pkt(d, 100, 8'h01, exp);
    n_checks++;
    if (got.size() != 101 || got != exp) begin
      n_fail++;
      $display("FAIL drop_pkt2: got %0d flits (or content differs), required 101 with pkt_id 01",
               got.size());
    end
    // GO on the tail-accept edge must be dropped.
    go = 1'b1;
    len = 64'd5;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_go_drop !== 16'd2 || o_busy !== 1'b0 || o_pkt_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL drop_on_tail: drop=%0d busy=%b cnt=%0d, required 2 0 2", o_go_drop, o_busy,
               o_pkt_cnt);
    end
  endtask

  task automatic test_headers();
    logic [7:0][63:0] d;
    fl_t got[$], exp[$];
    int first_c, tail_c, unstable;
    int nh[3] = '{3, 1, 8};
    int nl[3] = '{0, 0, 3};
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) d[i] = rnd_word(i != nh[t]);
      start_go(d, 64'(nl[t]));
      collect(-1, -1, 1'b1, -1, '0, 200, got, first_c, tail_c, unstable);
      build_pkt(d, longint'(nl[t]), 8'(t), exp);
      n_checks++;
      if (got.size() != nh[t] + nl[t] || got != exp) begin
        n_fail++;
        $display("FAIL headers_%0d: got %0d flits (or content differs), required %0d", t,
                 got.size(), nh[t] + nl[t]);
      end
      n_checks++;
      if (got.size() > 0 && !(got[0].head && got[got.size()-1].tail)) begin
        n_fail++;
        $display("FAIL headers_marks_%0d: first head=%b last tail=%b, required 1 1", t,
                 got[0].head, got[got.size()-1].tail);
      end
      n_checks++;
      if (unstable != 0) begin
        n_fail++;
        $display("FAIL headers_stable_%0d: %0d unstable stalls, required 0", t, unstable);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0][63:0] d = '0;
    fl_t got[$], exp[$];
    int first_c, tail_c, unstable;
    apply_reset();
    d[0] = rnd_word(1'b1);
    start_go(d, 64'd200);
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      go = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_pkt_cnt !== 32'd0 || o_tail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b busy=%b cnt=%0d tail=%b, required all 0", o_valid, o_busy,
               o_pkt_cnt, o_tail);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_go(d, 64'd20);
    collect(-1, -1, 1'b1, -1, '0, 500, got, first_c, tail_c, unstable);
    build_pkt(d, 20, 8'h00, exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d flits (or content differs), required 21 with pkt_id 00",
               got.size());
    end
    @(negedge clk);
    n_checks++;
    if (o_pkt_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_restart_cnt: got %0d, required 1", o_pkt_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0][63:0] d;
    fl_t got[$], exp[$];
    int first_c, tail_c, unstable;
    int exp_cnt = 0;
    int h, l;
    apply_reset();
    for (int t = 0; t < 8; t++) begin
      h = $urandom_range(1, 8);
      l = $urandom_range(0, 30);
      for (int i = 0; i < 8; i++) d[i] = rnd_word(i == 0 ? ($urandom_range(0, 1) == 1) : (i != h));
      start_go(d, 64'(l));
      collect(-1, -1, 1'b1, -1, '0, 1000, got, first_c, tail_c, unstable);
      build_pkt(d, longint'(l), 8'(exp_cnt), exp);
      exp_cnt++;
      n_checks++;
      if (got != exp || unstable != 0) begin
        n_fail++;
        $display("FAIL random_%0d: got %0d flits, required %0d; unstable=%0d", t, got.size(),
                 exp.size(), unstable);
      end
      @(negedge clk);
      n_checks++;
      if (o_pkt_cnt !== 32'(exp_cnt) || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_cnt_%0d: cnt=%0d busy=%b, required %0d 0", t, o_pkt_cnt, o_busy,
                 exp_cnt);
      end
    end
  endtask

  task automatic test_go_drop_sat();
    logic [7:0][63:0] d = '0;
    apply_reset();
    d[0] = rnd_word(1'b1);
    start_go(d, 64'd70000);
    @(negedge clk);
    go = 1'b1;
    repeat (65540) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_go_drop !== 16'hFFFF || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_saturate: drop=%h busy=%b, required ffff 1", o_go_drop, o_busy);
    end
    apply_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    bp    = 1'b0;
    len   = '0;
    dest  = '0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_go_drop();
    test_headers();
    test_reset_mid();
    test_random();
    test_go_drop_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/routex_pktgen.md
Name: routex_pktgen

Overview:
- Per-port packet source that sits directly upstream of a router input port.
- On a GO pulse it latches a source-route header (up to 8 hop words) and a payload length.
- It then emits one packet as a stream of 64-bit flits: header flits first, then payload flits, with HEAD/TAIL marking.
- It honours per-cycle back-pressure (BP) from the router port. One instance is used per router port in the verification harness.

Parameters:
- NumHops, 8, number of DEST hop words latched per packet.
- PortId, 0, 8-bit identifier stamped into payload flits.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- DEST  in  [NumHops-1:0][63:0]  route words; bits [63:56] nonzero marks a valid hop.
- LEN  in  64  payload flit count, sampled with GO.
- GO  in  1  single-cycle start request.
- BP  in  1  back-pressure; 1 = router cannot accept a flit this cycle.
- OUT_VALID  out  1  a flit is presented.
- OUT_DATA  out  64  flit data.
- OUT_HEAD  out  1  first flit of the packet.
- OUT_TAIL  out  1  last flit of the packet.
- BUSY  out  1  a packet is in progress (state != IDLE).
- PKT_CNT  out  32  packets fully sent (tail accepted).
- GO_DROP  out  16  GO pulses ignored because the block was busy; saturates at 16'hFFFF.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; OUT_VALID, OUT_HEAD, OUT_TAIL, BUSY = 0; OUT_DATA, PKT_CNT, GO_DROP = 0; latched DEST/LEN cleared. Reset mid-packet abandons the packet immediately; no tail is emitted.
- All outputs are registered.
- Transfer rule: a flit is accepted on an edge where OUT_VALID=1 and BP=0. While BP=1, OUT_DATA, OUT_HEAD and OUT_TAIL hold stable. BP is ignored when OUT_VALID=0.
- Header count H = index of the first DEST[i] with [63:56]==0, for i >= 1. DEST[0] is always sent, so H ranges 1..NumHops. H is computed from DEST as latched at GO.
- States:
  - IDLE: GO=1 latches DEST, LEN and H, loads hop index=0, and moves to HEAD. Next cycle OUT_VALID=1, OUT_DATA=DEST[0], OUT_HEAD=1 (latency GO -> first flit = 1 cycle).
  - HEAD: presents DEST[idx]. On accept of the last header flit: go to BODY if LEN>0; else that flit carries OUT_TAIL=1 and the block returns to IDLE.
  - BODY: presents payload flit k (k = 0..LEN-1), OUT_DATA = {PortId[7:0], pkt_id[7:0], k[47:0]}, where pkt_id = PKT_CNT[7:0] at packet start. OUT_TAIL=1 when k==LEN-1. On tail accept, go to IDLE.
- Back-to-back flits: after an accepted non-tail flit, the next flit is presented on the following cycle (no bubble).
- Tail accept edge: OUT_VALID falls, BUSY falls and PKT_CNT increments (32-bit wrap), all on the same edge.
- GO while BUSY=1, including the tail-accept cycle: ignored; GO_DROP increments, saturating.
- H=1 and LEN=0: single flit with OUT_HEAD=OUT_TAIL=1.
- LEN counter is 64-bit. Payload index k is truncated to 48 bits in the flit only.
- No combinational path from BP to any output.

Decomposition:
- Package routex_pktgen_pkg:
  - state enum {IDLE, HEAD, BODY};
  - flit_t struct {data[63:0], head, tail};
  - constant HOP_VALID_MSB=63, HOP_VALID_LSB=56.
- One sub-module, routex_hop_count: combinational first-invalid-hop finder over DEST returning H. Instantiated once and sampled at GO.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, BUSY=0.
- DEST[0]={8'h01,56'h4}, DEST[1..7]=0, LEN=500, GO pulse, BP=0:
  - 501 flits on consecutive cycles starting 1 cycle after GO;
  - flit0 = DEST[0] with HEAD;
  - flit500 = {PortId, 8'h00, 48'd499} with TAIL;
  - PKT_CNT=1.
- Same stimulus with BP=1 for cycles 40..140 after GO -> flits frozen and stable during BP; no flit lost or duplicated; total 501 flits; tail arrives 100 cycles later than without BP.
- GO with LEN=300, a second GO 10 cycles later, then GO with LEN=100 after the first tail -> GO_DROP=1; two packets of 301 and 101 flits; second packet's pkt_id=8'h01.
- DEST[0..2] valid, DEST[3]=0, LEN=0 -> 3 flits: HEAD on first, TAIL on third, no payload.
- Assert RST mid-BODY at flit 50 -> OUT_VALID=0 asynchronously; a new GO after release starts a fresh packet with PKT_CNT=0.
